// File: rtl/arb_requester_if.sv
// Command and arbiter req/gnt bundle for one requesting agent.
// master is the requester side; slave is the local datapath plus arbiter.
interface arb_requester_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             gnt;
    logic             req;
    logic             beat;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             abort;

    modport master (
        input  cmd_valid, cmd_len, gnt,
        output cmd_ready, req, beat, busy, done, timeout, abort
    );

    modport slave (
        output cmd_valid, cmd_len, gnt,
        input  cmd_ready, req, beat, busy, done, timeout, abort
    );
endinterface

// File: rtl/arb_requester.sv
// Requester end of a req/gnt arbiter: takes a burst command, requests, strobes cmd_len+1 beats.
// Outputs are registered one edge after the deciding gnt sample; new commands are held off until gnt is seen low.
module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input logic            clock,
    input logic            reset,
    arb_requester_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        RELEASE
    } state_t;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

    state_t           state;
    logic [LEN_W-1:0] beat_cnt;
    logic [TO_W-1:0]  wait_cnt;
    logic             req_q;
    logic             beat_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic             abort_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            req_q     <= 1'b0;
            beat_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        beat_cnt <= bus.cmd_len;
                        wait_cnt <= '0;
                        req_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // A grant on the limit cycle still wins over the timeout.
                    if (bus.gnt) begin
                        beat_q <= 1'b1;
                        state  <= XFER;
                    end else if (wait_cnt == WAIT_LAST) begin
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                XFER: begin
                    if (!bus.gnt) begin
                        req_q   <= 1'b0;
                        beat_q  <= 1'b0;
                        abort_q <= 1'b1;
                        state   <= RELEASE;
                    end else if (beat_cnt == '0) begin
                        req_q  <= 1'b0;
                        beat_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= RELEASE;
                    end else begin
                        beat_cnt <= beat_cnt - LEN_W'(1);
                    end
                end
                RELEASE: begin
                    // Absorb the arbiter's trailing or late grant before taking new work.
                    if (!bus.gnt) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.req       = req_q;
    assign bus.beat      = beat_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.abort     = abort_q;
endmodule
